// File: rtl/voice_allocator_if.sv
// Event handshake and packed lane outputs between the note source and the voice allocator.
interface voice_allocator_if #(
  parameter int unsigned NUM_BITS     = 32,
  parameter int unsigned NUM_CHANNELS = 16
);
  logic                             ev_valid;
  logic                             ev_ready;
  logic                             ev_on;
  logic [6:0]                       ev_key;
  logic [NUM_BITS-2:0]              ev_car;
  logic [NUM_BITS-1:0]              ev_mod;
  logic                             all_off;
  logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out;
  logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out;
  logic [NUM_CHANNELS-1:0]          available;
  logic                             ev_done;
  logic                             ev_drop;
  logic                             stolen;

  modport master (
    output ev_valid, ev_on, ev_key, ev_car, ev_mod, all_off,
    input  ev_ready, carrier_out, modulator_out, available, ev_done, ev_drop, stolen
  );

  modport slave (
    input  ev_valid, ev_on, ev_key, ev_car, ev_mod, all_off,
    output ev_ready, carrier_out, modulator_out, available, ev_done, ev_drop, stolen
  );
endinterface

// File: rtl/voice_allocator.sv
// Note-event scheduler: scans lanes per event for retrigger / lowest-free / oldest-steal targets.
// Optional feature macro: VOICE_STEAL_EN enables oldest-voice stealing when every lane is busy.
module voice_allocator #(
  parameter int unsigned NUM_BITS     = 32,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned AGE_BITS     = 8
) (
  input logic              clk,
  input logic              rst,
  voice_allocator_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);
  localparam int unsigned CAR_W = NUM_BITS - 1;
  localparam int unsigned KEY_W = 7;
  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;
  state_t state, state_next;

  logic [NUM_CHANNELS-1:0] en;
  logic [KEY_W-1:0]        key  [NUM_CHANNELS];
  logic [AGE_BITS-1:0]     age  [NUM_CHANNELS];
  logic [CAR_W-1:0]        car  [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     mods [NUM_CHANNELS];

  logic                ev_on_q;
  logic [KEY_W-1:0]    ev_key_q;
  logic [CAR_W-1:0]    ev_car_q;
  logic [NUM_BITS-1:0] ev_mod_q;

  logic [IDX_W-1:0] idx;
  logic             match_found, free_found;
  logic [IDX_W-1:0] match_idx, free_idx;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]    steal_idx;
  logic [AGE_BITS-1:0] steal_age;
`endif

  logic             ready_q, done_q, drop_q, stolen_q;
  logic             accept;
  logic             wr_on, wr_off, steal_c, done_c, drop_c;
  logic [IDX_W-1:0] tgt;

  assign accept = bus.ev_valid & ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; all_off aborts from anywhere
  always_comb begin
    state_next = state;
    if (bus.all_off) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = SCAN;
        SCAN:    if (idx == LAST_IDX) state_next = WRITE;
        WRITE:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Commit decode: target selection in retrigger > free > steal order
  always_comb begin
    wr_on   = 1'b0;
    wr_off  = 1'b0;
    steal_c = 1'b0;
    tgt     = '0;
    done_c  = 1'b0;
    drop_c  = 1'b0;
    if (bus.all_off) begin
      drop_c = (state != IDLE) || accept;
    end else if (state == WRITE) begin
      if (ev_on_q) begin
        if (match_found) begin
          wr_on = 1'b1;
          tgt   = match_idx;
        end else if (free_found) begin
          wr_on = 1'b1;
          tgt   = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else begin
          wr_on   = 1'b1;
          tgt     = steal_idx;
          steal_c = 1'b1;
        end
`endif
      end else if (match_found) begin
        wr_off = 1'b1;
        tgt    = match_idx;
      end
      done_c = wr_on | wr_off;
      drop_c = ~(wr_on | wr_off);
    end
  end

  // Event latch and per-lane scan bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_car_q    <= '0;
      ev_mod_q    <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
`ifdef VOICE_STEAL_EN
      steal_idx   <= '0;
      steal_age   <= '0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        ev_on_q     <= bus.ev_on;
        ev_key_q    <= bus.ev_key;
        ev_car_q    <= bus.ev_car;
        ev_mod_q    <= bus.ev_mod;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
      end
    end else if (state == SCAN) begin
      if (en[idx] && key[idx] == ev_key_q && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!en[idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
`ifdef VOICE_STEAL_EN
      if (idx == '0 || age[idx] > steal_age) begin
        steal_idx <= idx;
        steal_age <= age[idx];
      end
`endif
      idx <= idx + IDX_W'(1);
    end
  end

  // Lane state; all_off wins over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        key[i]  <= '0;
        age[i]  <= '0;
        car[i]  <= '0;
        mods[i] <= '0;
      end
    end else if (bus.all_off) begin
      en <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) age[i] <= '0;
    end else if (wr_on) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (IDX_W'(i) == tgt) begin
          en[i]   <= 1'b1;
          key[i]  <= ev_key_q;
          age[i]  <= '0;
          car[i]  <= ev_car_q;
          mods[i] <= ev_mod_q;
        end else if (en[i] && age[i] != AGE_MAX) begin
          age[i] <= age[i] + AGE_BITS'(1);
        end
      end
    end else if (wr_off) begin
      en[tgt] <= 1'b0;
    end
  end

  // Registered handshake and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      stolen_q <= 1'b0;
    end else begin
      ready_q  <= (state_next == IDLE);
      done_q   <= done_c;
      drop_q   <= drop_c;
      stolen_q <= steal_c;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    assign bus.carrier_out[NUM_BITS*i +: NUM_BITS]   = {en[i], car[i]};
    assign bus.modulator_out[NUM_BITS*i +: NUM_BITS] = mods[i];
  end

  assign bus.available = ~en;
  assign bus.ev_ready  = ready_q;
  assign bus.ev_done   = done_q;
  assign bus.ev_drop   = drop_q;
  assign bus.stolen    = stolen_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator with four lanes; expectations come from a lane model.
module tb_voice_allocator;
  localparam int unsigned NB = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned AB = 8;

  typedef logic [NB*NC-1:0] w_t;

  typedef struct {
    logic          done;
    logic          drop;
    logic          stolen;
    logic [NC-1:0] avail;
    w_t            car;
    w_t            mod;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_BITS(NB), .NUM_CHANNELS(NC)) bus ();

  voice_allocator #(.NUM_BITS(NB), .NUM_CHANNELS(NC), .AGE_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared;
  int mismatched;
  int cycle;
  exp_t sbq[$];

  bit          m_en  [NC];
  logic [6:0]  m_key [NC];
  int          m_age [NC];
  logic [NB-2:0] m_car [NC];
  logic [NB-1:0] m_mod [NC];

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 1'b0; m_key[i] = '0; m_age[i] = 0; m_car[i] = '0; m_mod[i] = '0;
    end
  endtask

  task automatic model_all_off();
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 1'b0; m_age[i] = 0;
    end
  endtask

  task automatic model_event(input bit on, input logic [6:0] k, input logic [NB-2:0] c,
                             input logic [NB-1:0] m, output exp_t e);
    int t;
    bit st;
    t  = -1;
    st = 1'b0;
    for (int i = 0; i < NC; i++) if (t < 0 && m_en[i] && m_key[i] == k) t = i;
    if (on) begin
      for (int i = 0; i < NC; i++) if (t < 0 && !m_en[i]) t = i;
`ifdef VOICE_STEAL_EN
      if (t < 0) begin
        t = 0;
        for (int i = 1; i < NC; i++) if (m_age[i] > m_age[t]) t = i;
        st = 1'b1;
      end
`endif
      if (t >= 0) begin
        for (int i = 0; i < NC; i++) begin
          if (i == t) begin
            m_en[i] = 1'b1; m_key[i] = k; m_age[i] = 0; m_car[i] = c; m_mod[i] = m;
          end else if (m_en[i] && m_age[i] < (1 << AB) - 1) begin
            m_age[i] = m_age[i] + 1;
          end
        end
      end
    end else if (t >= 0) begin
      m_en[t] = 1'b0;
    end
    e.done   = (t >= 0);
    e.drop   = (t < 0);
    e.stolen = st;
    e.car    = '0;
    e.mod    = '0;
    for (int i = 0; i < NC; i++) begin
      e.avail[i]          = ~m_en[i];
      e.car[NB*i +: NB]   = {m_en[i], m_car[i]};
      e.mod[NB*i +: NB]   = m_mod[i];
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ev_ready && n < 50) begin step(); n++; end
    chk("ready_wait", w_t'(bus.ev_ready), w_t'(1));
  endtask

  task automatic send(input bit on, input logic [6:0] k, input logic [NB-2:0] c,
                      input logic [NB-1:0] m);
    exp_t e, g;
    int n;
    bit seen;
    bus.ev_valid = 1'b1; bus.ev_on = on; bus.ev_key = k; bus.ev_car = c; bus.ev_mod = m;
    wait_ready();
    step();
    model_event(on, k, c, m, e);
    sbq.push_back(e);
    bus.ev_valid = 1'b0;
    chk("ready_low_after_accept", w_t'(bus.ev_ready), w_t'(0));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3 * NC) begin
      step(); n++;
      seen = bus.ev_done | bus.ev_drop;
    end
    chk("latency", w_t'(n), w_t'(NC + 1));
    g = sbq.pop_front();
    chk("ev_done", w_t'(bus.ev_done), w_t'(g.done));
    chk("ev_drop", w_t'(bus.ev_drop), w_t'(g.drop));
    chk("stolen", w_t'(bus.stolen), w_t'(g.stolen));
    chk("available", w_t'(bus.available), w_t'(g.avail));
    chk("carrier_out", bus.carrier_out, g.car);
    chk("modulator_out", bus.modulator_out, g.mod);
    chk("ready_at_commit", w_t'(bus.ev_ready), w_t'(1));
    step();
    chk("pulse_one_cycle", w_t'({bus.ev_done, bus.ev_drop, bus.stolen}), w_t'(0));
  endtask

  initial begin
    int acc[$];
    int n;
    bit any;
    compared = 0; mismatched = 0; cycle = 0;
    rst = 1'b1;
    bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_key = '0;
    bus.ev_car = '0; bus.ev_mod = '0; bus.all_off = 1'b0;
    model_reset();
    repeat (3) step();

    chk("reset_available", w_t'(bus.available), w_t'(4'hF));
    chk("reset_carrier", bus.carrier_out, w_t'(0));
    chk("reset_modulator", bus.modulator_out, w_t'(0));
    chk("reset_ready", w_t'(bus.ev_ready), w_t'(0));
    chk("reset_pulses", w_t'({bus.ev_done, bus.ev_drop, bus.stolen}), w_t'(0));
    rst = 1'b0;
    step();
    chk("ready_after_reset", w_t'(bus.ev_ready), w_t'(1));

    // First allocation lands in lane 0
    send(1'b1, 7'd60, 31'h100, 32'h40);
    chk("lane0_carrier", w_t'(bus.carrier_out[NB-1:0]), w_t'(32'h8000_0100));
    chk("lane0_modulator", w_t'(bus.modulator_out[NB-1:0]), w_t'(32'h40));
    chk("avail_one_lane", w_t'(bus.available), w_t'(4'b1110));

    send(1'b1, 7'd62, 31'h120, 32'h41);
    send(1'b1, 7'd64, 31'h140, 32'h42);
    send(1'b0, 7'd62, 31'h0, 32'h0);
    chk("avail_after_off", w_t'(bus.available), w_t'(4'b1010));
    send(1'b0, 7'd70, 31'h0, 32'h0);
    chk("avail_after_drop", w_t'(bus.available), w_t'(4'b1010));

    // Retrigger of key 60 reuses lane 0
    send(1'b1, 7'd60, 31'h200, 32'h50);
    chk("retrigger_lane0", w_t'(bus.carrier_out[NB-1:0]), w_t'(32'h8000_0200));
    chk("retrigger_avail", w_t'(bus.available), w_t'(4'b1010));

    bus.all_off = 1'b1;
    step();
    bus.all_off = 1'b0;
    model_all_off();
    chk("alloff_idle_avail", w_t'(bus.available), w_t'(4'hF));
    chk("alloff_idle_nodrop", w_t'(bus.ev_drop), w_t'(0));

    // Fill every lane, then one more note-on
    send(1'b1, 7'd1, 31'h11, 32'h21);
    send(1'b1, 7'd2, 31'h12, 32'h22);
    send(1'b1, 7'd3, 31'h13, 32'h23);
    send(1'b1, 7'd4, 31'h14, 32'h24);
    chk("full_avail", w_t'(bus.available), w_t'(4'h0));
    send(1'b1, 7'd5, 31'h55, 32'h25);
`ifdef VOICE_STEAL_EN
    chk("steal_lane0", w_t'(bus.carrier_out[NB-1:0]), w_t'(32'h8000_0055));
`else
    chk("nosteal_lane0", w_t'(bus.carrier_out[NB-1:0]), w_t'(32'h8000_0011));
`endif

    // all_off while the event is scanning
    bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_key = 7'd9;
    bus.ev_car = 31'h9; bus.ev_mod = 32'h9;
    wait_ready();
    step();
    bus.ev_valid = 1'b0;
    step(); step();
    bus.all_off = 1'b1;
    step();
    bus.all_off = 1'b0;
    model_all_off();
    chk("abort_avail", w_t'(bus.available), w_t'(4'hF));
    chk("abort_drop", w_t'(bus.ev_drop), w_t'(1));
    chk("abort_nodone", w_t'(bus.ev_done), w_t'(0));
    chk("abort_ready", w_t'(bus.ev_ready), w_t'(1));
    any = 1'b0;
    for (int i = 0; i < NC + 2; i++) begin
      step();
      any = any | bus.ev_done | bus.ev_drop;
    end
    chk("abort_no_late_pulse", w_t'(any), w_t'(0));

    // Back-to-back accepts with ev_valid held high
    bus.ev_valid = 1'b1; bus.ev_on = 1'b0; bus.ev_key = 7'd99;
    n = 0;
    while (acc.size() < 3 && n < 100) begin
      if (bus.ev_ready) acc.push_back(cycle + 1);
      step(); n++;
    end
    bus.ev_valid = 1'b0;
    chk("hold_accept_count", w_t'(acc.size()), w_t'(3));
    if (acc.size() == 3) begin
      chk("hold_spacing_1", w_t'(acc[1] - acc[0]), w_t'(NC + 2));
      chk("hold_spacing_2", w_t'(acc[2] - acc[1]), w_t'(NC + 2));
    end
    repeat (NC + 3) step();

    // Reset in the middle of a scan
    send(1'b1, 7'd40, 31'h40, 32'h44);
    bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_key = 7'd41;
    bus.ev_car = 31'h41; bus.ev_mod = 32'h45;
    wait_ready();
    step();
    bus.ev_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    model_reset();
    chk("midrst_carrier", bus.carrier_out, w_t'(0));
    chk("midrst_modulator", bus.modulator_out, w_t'(0));
    chk("midrst_available", w_t'(bus.available), w_t'(4'hF));
    chk("midrst_ready", w_t'(bus.ev_ready), w_t'(0));
    chk("midrst_pulses", w_t'({bus.ev_done, bus.ev_drop, bus.stolen}), w_t'(0));
    rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < NC + 2; i++) begin
      step();
      any = any | bus.ev_done | bus.ev_drop;
    end
    chk("midrst_no_pulse", w_t'(any), w_t'(0));
    send(1'b1, 7'd33, 31'h3, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Note-event scheduler that maps incoming note-on/note-off events onto the NUM_CHANNELS FM voice lanes. It owns the packed per-lane carrier and modulator word registers that feed the channel sequencer and the operator datapath. It also drives the per-lane `available` flags. Each event is sequenced by a scan FSM that does key-match retrigger, then lowest-free allocation, then optional oldest-voice stealing.

## Interface
Parameters:
- NUM_BITS, 32, width of one lane word; carrier lane MSB is the note-enable bit
- NUM_CHANNELS, 16, number of voice lanes (≥2)
- AGE_BITS, 8, width of per-lane age counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ev_valid  in  1  event offered
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  7  note number
- ev_car  in  NUM_BITS-1  carrier phase increment, lane bits [NUM_BITS-2:0]
- ev_mod  in  NUM_BITS  modulator phase increment
- all_off  in  1  clear every lane's enable
- carrier_out  out  NUM_BITS*NUM_CHANNELS  packed lanes: {enable, car word}; lane i at [NUM_BITS*(i+1)-1:NUM_BITS*i]
- modulator_out  out  NUM_BITS*NUM_CHANNELS  packed modulator words, same lane packing
- available  out  NUM_CHANNELS  bit i = ~enable of lane i
- ev_done  out  1  one-cycle pulse: event committed
- ev_drop  out  1  one-cycle pulse: event discarded
- stolen  out  1  one-cycle pulse, coincident with ev_done: an active lane was overwritten

## Operation
- State per lane: enable, key[6:0], age[AGE_BITS-1:0], car word, mod word.
- FSM states: IDLE, SCAN, WRITE.
  - IDLE: ev_ready=1. On ev_valid&ev_ready, latch ev_*; set idx=0; go to SCAN.
  - SCAN: evaluate lane idx once per cycle, idx 0..NUM_CHANNELS-1; after idx=NUM_CHANNELS-1, go to WRITE.
- Note-on lane selection, in priority order:
  1. First enabled lane whose key equals ev_key (retrigger).
  2. Otherwise the lowest-index disabled lane.
  3. Otherwise (all lanes busy) the steal candidate: highest age, lowest index on tie.
- Note-off: target is the first enabled lane with a matching key; no match gives a drop.
- WRITE for note-on: the target lane is written with enable=1, key, car, mod, age=0. Every other enabled lane's age increments, saturating at 2^AGE_BITS-1. `stolen`=1 if the target was chosen by rule 3.
- WRITE for note-off: the target lane's enable clears; its words, key and age are retained.
- Without a target, no state changes and ev_drop pulses instead of ev_done. Then go to IDLE.
- all_off, any state: all enables cleared and all ages zeroed at the next edge. An in-flight event is aborted: go to IDLE, ev_drop pulses, no ev_done. all_off takes priority over a simultaneous WRITE.
- Reset values:
  - carrier_out=0, modulator_out=0, available=all ones
  - keys and ages 0
  - ev_done=ev_drop=stolen=0
  - state IDLE; ev_ready=0 while rst is high

## Timing
- Accept on edge k (ev_valid&ev_ready).
- SCAN occupies edges k+1..k+NUM_CHANNELS.
- WRITE edge k+NUM_CHANNELS+1: lane registers, available, ev_done/ev_drop/stolen update together. The pulses last exactly one cycle.
- ev_ready is 0 from after edge k until after edge k+NUM_CHANNELS+1. Throughput is one event per NUM_CHANNELS+2 cycles.
- ev_valid may deassert freely while ev_ready=0. ev_* are sampled only at the accept edge.
- Outputs are fully registered; no combinational path from ev_* to lane outputs.
- Lane updates may land mid sequencer sweep; the downstream sequencer tolerates per-lane changes between frames.
- rst mid-event aborts immediately to the reset values; no pulses.

## Configuration
- VOICE_STEAL_EN defined: rule 3 is active; a note-on never drops.
- VOICE_STEAL_EN undefined: no steal candidate is tracked and `stolen` is tied to 0. A note-on with all lanes enabled and no key match is dropped (ev_drop pulse, no state change).
- Ages are still maintained in both builds.

## Test plan
- Reset, then note-on key 60, car 0x100, mod 0x40 → ev_done at accept+NUM_CHANNELS+1; lane 0 = {1, 0x100}/0x40; available[0]=0, others 1.
- Note-on keys 60, 62, 64 then note-off 62 → lane 1 enable cleared, available=…1010 (lanes 0 and 2 busy); note-off key 70 → ev_drop, lanes unchanged.
- Note-on key 60 again with car 0x200 → lane 0 rewritten (retrigger), no new lane used, stolen=0.
- NUM_CHANNELS=4, notes 1, 2, 3, 4 fill all lanes; note-on 5 → lane 0 (oldest, age 3) overwritten, stolen=1 (with VOICE_STEAL_EN). Without the macro → ev_drop, lanes unchanged.
- all_off asserted during SCAN → next cycle available all ones, ev_drop pulse, no ev_done, ev_ready=1.
- Hold ev_valid high continuously → accepts spaced exactly NUM_CHANNELS+2 cycles; rst mid-SCAN → all outputs at reset values next cycle, no pulses.
